rbt_s_proto_hdr_collector: RTL

- Stage directly upstream of the transport-layer parser. Collects the leading bytes of each AXI-Stream packet into one HEADER_WIDTH-bit header word.
- Packs the bytes MSB-first, so the first packet byte lands in bits [HEADER_WIDTH-1 -: 8].
- Emits the header word with its captured byte length and the packet metadata on the proto_hdr valid/ready interface. Payload beats beyond the header are consumed and discarded.

---
 rtl/rbt_s_parser_pkg.sv | 27 ++
 rtl/rbt_s_proto_hdr_collector_if.sv | 58 +++++
 rtl/rbt_s_keep_popcount.sv | 23 ++
 rtl/rbt_s_proto_hdr_collector.sv | 134 +++++++++++++
 4 files changed

// File: rtl/rbt_s_parser_pkg.sv
// -----------------------------------------------------------------------------
// rbt_s_parser_pkg
// Definitions shared by the transport-layer parser stages:
//   - hdr_state_e : header collector state encoding
//   - PKT_METADATA_WIDTH_DEFAULT : default packet metadata width
//   - metadata field offsets/widths consumed by the parser
//     (PROTO_NO, PKT_PROPERTY_NO, PKT_RPN_NO), LSB-relative
// -----------------------------------------------------------------------------
package rbt_s_parser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_OUTPUT  = 2'd3
  } hdr_state_e;

  localparam int PKT_METADATA_WIDTH_DEFAULT = 272;

  localparam int PROTO_NO_OFFSET        = 0;
  localparam int PROTO_NO_WIDTH         = 8;
  localparam int PKT_PROPERTY_NO_OFFSET = 8;
  localparam int PKT_PROPERTY_NO_WIDTH  = 16;
  localparam int PKT_RPN_NO_OFFSET      = 24;
  localparam int PKT_RPN_NO_WIDTH       = 8;

endpackage

// File: rtl/rbt_s_proto_hdr_collector_if.sv
// -----------------------------------------------------------------------------
// rbt_s_proto_hdr_collector_if
// Bundles the AXI-Stream input and the proto_hdr valid/ready output of the
// header collector.
//   slave  : collector view (consumes s_axis_*, produces out_proto_hdr_*)
//   master : environment view (produces s_axis_*, consumes out_proto_hdr_*)
// Optional signal out_proto_hdr_truncated exists only when
// RBT_S_HDR_COLLECT_TRUNC_FLAG_EN is defined.
// -----------------------------------------------------------------------------
interface rbt_s_proto_hdr_collector_if
  import rbt_s_parser_pkg::*;
#(
  parameter int DATA_WIDTH         = 512,
  parameter int KEEP_WIDTH         = DATA_WIDTH/8,
  parameter int HEADER_WIDTH       = 2048,
  parameter int PKT_METADATA_WIDTH = PKT_METADATA_WIDTH_DEFAULT
);
  logic [DATA_WIDTH-1:0]         s_axis_tdata;
  logic [KEEP_WIDTH-1:0]         s_axis_tkeep;
  logic                          s_axis_tvalid;
  logic                          s_axis_tready;
  logic                          s_axis_tlast;
  logic [PKT_METADATA_WIDTH-1:0] s_axis_pkt_metadata;

  logic                          out_proto_hdr_valid;
  logic                          out_proto_hdr_ready;
  logic [HEADER_WIDTH-1:0]       out_proto_hdr_data;
  logic [15:0]                   out_proto_hdr_length;
  logic [PKT_METADATA_WIDTH-1:0] out_proto_hdr_pkt_metadata;
`ifdef RBT_S_HDR_COLLECT_TRUNC_FLAG_EN
  logic                          out_proto_hdr_truncated;
`endif

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  s_axis_pkt_metadata,
    output s_axis_tready,
    output out_proto_hdr_valid, out_proto_hdr_data, out_proto_hdr_length,
`ifdef RBT_S_HDR_COLLECT_TRUNC_FLAG_EN
    output out_proto_hdr_truncated,
`endif
    output out_proto_hdr_pkt_metadata,
    input  out_proto_hdr_ready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output s_axis_pkt_metadata,
    input  s_axis_tready,
    input  out_proto_hdr_valid, out_proto_hdr_data, out_proto_hdr_length,
`ifdef RBT_S_HDR_COLLECT_TRUNC_FLAG_EN
    input  out_proto_hdr_truncated,
`endif
    input  out_proto_hdr_pkt_metadata,
    output out_proto_hdr_ready
  );

endinterface

// File: rtl/rbt_s_keep_popcount.sv
// -----------------------------------------------------------------------------
// rbt_s_keep_popcount
// Combinational byte count of an AXI-Stream tkeep vector.
// Ports:
//   keep  in  KEEP_WIDTH  byte enables
//   count out CNT_W       number of set bits in keep
// -----------------------------------------------------------------------------
module rbt_s_keep_popcount #(
  parameter int KEEP_WIDTH = 64,
  parameter int CNT_W      = $clog2(KEEP_WIDTH+1)
) (
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [CNT_W-1:0]      count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      count = count + CNT_W'(keep[i]);
    end
  end

endmodule

// File: rtl/rbt_s_proto_hdr_collector.sv
// -----------------------------------------------------------------------------
// rbt_s_proto_hdr_collector
// Collects the leading HEADER_WIDTH/8 bytes of each AXI-Stream packet into one
// MSB-first header word (packet byte 0 lands in the top byte), reports the
// captured byte count and the first-beat metadata on the proto_hdr interface,
// and discards payload beats past the header.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    rbt_s_proto_hdr_collector_if.slave
//          s_axis_*        : packet input (tdata/tkeep/tvalid/tready/tlast/
//                            pkt_metadata)
//          out_proto_hdr_* : header output (valid/ready/data/length/
//                            pkt_metadata[/truncated])
// Optional build macro: RBT_S_HDR_COLLECT_TRUNC_FLAG_EN adds
// out_proto_hdr_truncated, set when any beat was dropped while draining.
// -----------------------------------------------------------------------------
module rbt_s_proto_hdr_collector
  import rbt_s_parser_pkg::*;
#(
  parameter int DATA_WIDTH         = 512,
  parameter int KEEP_WIDTH         = DATA_WIDTH/8,
  parameter int HEADER_WIDTH       = 2048,
  parameter int PKT_METADATA_WIDTH = PKT_METADATA_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  rbt_s_proto_hdr_collector_if.slave bus
);

  localparam int HDR_BEATS = HEADER_WIDTH/DATA_WIDTH;
  localparam int HDR_BYTES = HEADER_WIDTH/8;
  localparam int IDX_W     = $clog2(HDR_BEATS+1);
  localparam int PC_W      = $clog2(KEEP_WIDTH+1);

  hdr_state_e                    state;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              widx;
  logic [15:0]                   cnt;
  logic [15:0]                   cnt_base;
  logic [HEADER_WIDTH-1:0]       hdr;
  logic [PKT_METADATA_WIDTH-1:0] meta;
  logic [PC_W-1:0]               pop;
  logic [DATA_WIDTH-1:0]         masked;
  logic                          hshake;
  logic                          first;
  logic                          accept;
`ifdef RBT_S_HDR_COLLECT_TRUNC_FLAG_EN
  logic                          trunc;
`endif

  function automatic logic [15:0] sat_len(input logic [16:0] sum);
    return (sum > 17'(HDR_BYTES)) ? 16'(HDR_BYTES) : sum[15:0];
  endfunction

  rbt_s_keep_popcount #(
    .KEEP_WIDTH(KEEP_WIDTH),
    .CNT_W     (PC_W)
  ) u_keep_popcount (
    .keep (bus.s_axis_tkeep),
    .count(pop)
  );

  // tkeep bit KEEP_WIDTH-1 enables byte 0 (the top byte of tdata).
  always_comb begin
    masked = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      masked[DATA_WIDTH-1-8*k -: 8] = bus.s_axis_tdata[DATA_WIDTH-1-8*k -: 8]
                                      & {8{bus.s_axis_tkeep[KEEP_WIDTH-1-k]}};
    end
  end

  assign hshake = (state == ST_OUTPUT) && bus.out_proto_hdr_ready;
  // tready is forced low while reset is asserted, even though state is IDLE.
  assign bus.s_axis_tready = rst_n && ((state != ST_OUTPUT) || bus.out_proto_hdr_ready);
  assign accept = bus.s_axis_tvalid && bus.s_axis_tready;
  // A beat accepted during an output handshake starts a fresh packet, so it
  // sees a cleared index/count just like a beat taken in IDLE.
  assign first    = (state == ST_IDLE) || hshake;
  assign widx     = first ? '0 : idx;
  assign cnt_base = first ? '0 : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      hdr   <= '0;
      meta  <= '0;
`ifdef RBT_S_HDR_COLLECT_TRUNC_FLAG_EN
      trunc <= 1'b0;
`endif
    end else begin
      if (hshake) begin
        state <= ST_IDLE;
        idx   <= '0;
        cnt   <= '0;
        hdr   <= '0;
`ifdef RBT_S_HDR_COLLECT_TRUNC_FLAG_EN
        trunc <= 1'b0;
`endif
      end
      // Assignments below override the clear above for the same-cycle
      // first beat of the next packet.
      if (accept) begin
        if (state == ST_DRAIN) begin
`ifdef RBT_S_HDR_COLLECT_TRUNC_FLAG_EN
          trunc <= 1'b1;
`endif
          if (bus.s_axis_tlast) state <= ST_OUTPUT;
        end else begin
          for (int b = 0; b < HDR_BEATS; b++) begin
            if (widx == IDX_W'(b)) hdr[HEADER_WIDTH-1-b*DATA_WIDTH -: DATA_WIDTH] <= masked;
          end
          cnt <= sat_len({1'b0, cnt_base} + 17'(pop));
          idx <= widx + IDX_W'(1);
          if (first) meta <= bus.s_axis_pkt_metadata;
          if (bus.s_axis_tlast)                 state <= ST_OUTPUT;
          else if (widx == IDX_W'(HDR_BEATS-1)) state <= ST_DRAIN;
          else                                  state <= ST_COLLECT;
        end
      end
    end
  end

  assign bus.out_proto_hdr_valid        = (state == ST_OUTPUT);
  assign bus.out_proto_hdr_data         = hdr;
  assign bus.out_proto_hdr_length       = cnt;
  assign bus.out_proto_hdr_pkt_metadata = meta;
`ifdef RBT_S_HDR_COLLECT_TRUNC_FLAG_EN
  assign bus.out_proto_hdr_truncated    = trunc;
`endif

endmodule
